// File: rtl/vector_pkg.sv
// Shared types and constants for the beam scheduler slice.
// Provides the DAC coordinate width, the point payload, the scheduler state
// encoding and the default park coordinates.
package vector_pkg;

    localparam int unsigned DAC_W      = 8;
    localparam int unsigned PARK_X_DEF = 128;
    localparam int unsigned PARK_Y_DEF = 128;

    typedef struct packed {
        logic [DAC_W-1:0] x;
        logic [DAC_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        CUR  = 2'd1,
        VEC  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/dac_dwell_timer.sv
// Dwell timer: loadable down-counter that holds each DAC point.
// Ports: clk, rst (sync, active-high), load (start a dwell of DWELL cycles),
//        done (counter at zero, a new point may be accepted).
module dac_dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int unsigned CW = $clog2(DWELL + 1);

    logic [CW-1:0] dwell_cnt;

    // Load DWELL-1 so the point is held DWELL cycles including the load cycle; saturate at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if (load) begin
            dwell_cnt <= CW'(DWELL - 1);
        end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - CW'(1);
        end
    end

    assign done = (dwell_cnt == '0);

endmodule

// File: rtl/dac_beam_scheduler.sv
// Beam scheduler: shares the X/Y DAC pair between the cursor overlay and the
// vector stream. Each frame runs a bounded cursor window, then vectors, then parks.
// Ports: clk, rst (sync, active-high), frame_tick, vec_* (vector point stream
//        with last marker), cur_* (cursor point stream), xch/ych (DAC codes),
//        go_flag/halt_flag (drawing/parked), frame_overrun (tick while busy).
module dac_beam_scheduler
    import vector_pkg::*;
#(
    parameter int unsigned W       = DAC_W,
    parameter int unsigned DWELL   = 4,
    parameter int unsigned CUR_PTS = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned PARK_X  = PARK_X_DEF,
    parameter int unsigned PARK_Y  = PARK_Y_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         vec_valid,
    input  logic [W-1:0] vec_x,
    input  logic [W-1:0] vec_y,
    input  logic         vec_last,
    output logic         vec_ready,
    input  logic         cur_valid,
    input  logic [W-1:0] cur_x,
    input  logic [W-1:0] cur_y,
    output logic         cur_ready,
    output logic [W-1:0] xch,
    output logic [W-1:0] ych,
    output logic         go_flag,
    output logic         halt_flag,
    output logic         frame_overrun
);

    localparam int unsigned CC_W = $clog2(CUR_PTS + 1);
    localparam int unsigned IC_W = $clog2(TIMEOUT + 1);

    sched_state_t    state;
    sched_state_t    state_nxt;
    logic [CC_W-1:0] cur_cnt;
    logic [IC_W-1:0] idle_cnt;
    logic            tick_pending;
    logic            last_pending;
    logic            dwell_done;
    logic            cur_xfer;
    logic            vec_xfer;
    logic            idle_expired;

    dac_dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (cur_xfer | vec_xfer),
        .done (dwell_done)
    );

    // Readies depend on registers only; the last vector point blocks further
    // vector transfers while its dwell runs out.
    assign vec_ready    = (state == VEC) && dwell_done && !last_pending;
    assign cur_ready    = (state == CUR) && dwell_done && (cur_cnt != '0);
    assign cur_xfer     = cur_valid && cur_ready;
    assign vec_xfer     = vec_valid && vec_ready;
    assign idle_expired = !vec_xfer && (idle_cnt == IC_W'(TIMEOUT - 1));

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            PARK: if (frame_tick || tick_pending) state_nxt = CUR;
            CUR:  if (dwell_done && ((cur_cnt == '0) || !cur_valid)) state_nxt = VEC;
            VEC:  if ((last_pending && dwell_done) || idle_expired) state_nxt = PARK;
            default: state_nxt = PARK;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PARK;
            xch           <= W'(PARK_X);
            ych           <= W'(PARK_Y);
            go_flag       <= 1'b0;
            halt_flag     <= 1'b1;
            frame_overrun <= 1'b0;
            cur_cnt       <= '0;
            idle_cnt      <= '0;
            tick_pending  <= 1'b0;
            last_pending  <= 1'b0;
        end else begin
            state         <= state_nxt;
            go_flag       <= (state_nxt == CUR) || (state_nxt == VEC);
            halt_flag     <= (state_nxt == PARK);
            frame_overrun <= frame_tick && (state != PARK);

            // A tick while busy is remembered; leaving PARK consumes it.
            if (frame_tick && (state != PARK)) begin
                tick_pending <= 1'b1;
            end else if ((state == PARK) && (state_nxt == CUR)) begin
                tick_pending <= 1'b0;
            end

            if ((state == PARK) && (state_nxt == CUR)) begin
                cur_cnt <= CC_W'(CUR_PTS);
            end else if (cur_xfer && (cur_cnt != '0)) begin
                cur_cnt <= cur_cnt - CC_W'(1);
            end

            if ((state == CUR) && (state_nxt == VEC)) begin
                idle_cnt <= '0;
            end else if (state == VEC) begin
                if (vec_xfer) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != IC_W'(TIMEOUT - 1)) begin
                    idle_cnt <= idle_cnt + IC_W'(1);
                end
            end

            if (state_nxt == PARK) begin
                last_pending <= 1'b0;
            end else if (vec_xfer && vec_last) begin
                last_pending <= 1'b1;
            end

            if (state_nxt == PARK) begin
                xch <= W'(PARK_X);
                ych <= W'(PARK_Y);
            end else if (cur_xfer) begin
                xch <= cur_x;
                ych <= cur_y;
            end else if (vec_xfer) begin
                xch <= vec_x;
                ych <= vec_y;
            end
        end
    end

endmodule

// File: tb/tb_dac_beam_scheduler.sv
// Scoreboard bench for dac_beam_scheduler (DWELL=4, CUR_PTS=2, TIMEOUT=16).
// Stimulus pushes the expected DAC output segments (x, y, go, halt, length);
// a monitor pops one entry each time the output tuple changes.
module tb_dac_beam_scheduler;

    localparam int unsigned W       = 8;
    localparam int unsigned DWELL   = 4;
    localparam int unsigned CUR_PTS = 2;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       go;
        logic       halt;
        logic [7:0] len;
    } exp_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       last;
    } pt_t;

    logic         clk;
    logic         rst;
    logic         frame_tick;
    logic         vec_valid;
    logic [W-1:0] vec_x;
    logic [W-1:0] vec_y;
    logic         vec_last;
    logic         vec_ready;
    logic         cur_valid;
    logic [W-1:0] cur_x;
    logic [W-1:0] cur_y;
    logic         cur_ready;
    logic [W-1:0] xch;
    logic [W-1:0] ych;
    logic         go_flag;
    logic         halt_flag;
    logic         frame_overrun;

    exp_t exp_q[$];
    pt_t  cur_q[$];
    pt_t  vec_q[$];
    int   checks;
    int   errors;
    int   cur_fires;
    int   ovr_cycles;
    bit   mon_en;

    dac_beam_scheduler #(
        .W(W), .DWELL(DWELL), .CUR_PTS(CUR_PTS), .TIMEOUT(TIMEOUT),
        .PARK_X(128), .PARK_Y(128)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .vec_valid(vec_valid), .vec_x(vec_x), .vec_y(vec_y), .vec_last(vec_last),
        .vec_ready(vec_ready),
        .cur_valid(cur_valid), .cur_x(cur_x), .cur_y(cur_y), .cur_ready(cur_ready),
        .xch(xch), .ych(ych), .go_flag(go_flag), .halt_flag(halt_flag),
        .frame_overrun(frame_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input bit go, input bit halt, input int len);
        exp_t e;
        e.x = 8'(x); e.y = 8'(y); e.go = go; e.halt = halt; e.len = 8'(len);
        return e;
    endfunction

    function automatic pt_t pt(input int x, input int y, input bit last);
        pt_t p;
        p.x = 8'(x); p.y = 8'(y); p.last = last;
        return p;
    endfunction

    // Point sources: handshake sampled at negedge, queue advanced after the edge.
    initial begin
        bit cf;
        bit vf;
        cur_valid = 1'b0; cur_x = '0; cur_y = '0;
        vec_valid = 1'b0; vec_x = '0; vec_y = '0; vec_last = 1'b0;
        forever begin
            @(negedge clk);
            cf = cur_valid && cur_ready;
            vf = vec_valid && vec_ready;
            if (cf) cur_fires++;
            if (frame_overrun) ovr_cycles++;
            @(posedge clk);
            #1;
            if (cf && cur_q.size() != 0) void'(cur_q.pop_front());
            if (vf && vec_q.size() != 0) void'(vec_q.pop_front());
            cur_valid = (cur_q.size() != 0);
            if (cur_q.size() != 0) begin
                cur_x = cur_q[0].x; cur_y = cur_q[0].y;
            end
            vec_valid = (vec_q.size() != 0);
            if (vec_q.size() != 0) begin
                vec_x = vec_q[0].x; vec_y = vec_q[0].y; vec_last = vec_q[0].last;
            end else begin
                vec_last = 1'b0;
            end
        end
    end

    // Monitor: each change of the DAC tuple consumes one expected segment.
    initial begin
        logic [17:0] prev;
        logic [17:0] now;
        int          run;
        int          exp_len;
        exp_t        e;
        prev = {8'd128, 8'd128, 1'b0, 1'b1};
        run = 0;
        exp_len = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                now = {xch, ych, go_flag, halt_flag};
                if (now != prev) begin
                    if (exp_len != 0) chk("segment_length", run, exp_len);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output_change", now, prev);
                        exp_len = 0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("dac_tuple", now, {e.x, e.y, e.go, e.halt});
                        exp_len = int'(e.len);
                    end
                    prev = now;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic wait_halt(input logic lvl, input string nm);
        int n;
        n = 0;
        while (halt_flag !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (halt_flag !== lvl) chk(nm, halt_flag, lvl);
    endtask

    initial begin
        int base;
        checks = 0; errors = 0; cur_fires = 0; ovr_cycles = 0; mon_en = 1'b0;
        rst = 1'b1;
        frame_tick = 1'b1;

        // 1: reset dominates a held frame_tick
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_xch", xch, 128);
        chk("rst_ych", ych, 128);
        chk("rst_halt", halt_flag, 1);
        chk("rst_go", go_flag, 0);
        chk("rst_vec_ready", vec_ready, 0);
        chk("rst_cur_ready", cur_ready, 0);
        frame_tick = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_halt", halt_flag, 1);
        chk("post_rst_overrun", frame_overrun, 0);
        mon_en = 1'b1;

        // 2+3: two cursor points of three offered, then a two-point vector list
        @(negedge clk);
        cur_q.push_back(pt(10, 20, 0));
        cur_q.push_back(pt(11, 21, 0));
        cur_q.push_back(pt(12, 22, 0));
        vec_q.push_back(pt(50, 60, 0));
        vec_q.push_back(pt(70, 80, 1));
        exp_q.push_back(mk(128, 128, 1, 0, 1));
        exp_q.push_back(mk(10, 20, 1, 0, 4));
        exp_q.push_back(mk(11, 21, 1, 0, 5));
        exp_q.push_back(mk(50, 60, 1, 0, 4));
        exp_q.push_back(mk(70, 80, 1, 0, 4));
        exp_q.push_back(mk(128, 128, 0, 1, 0));
        tick();
        wait_halt(1'b0, "t2_start_timeout");
        wait_halt(1'b1, "t3_park_timeout");
        chk("t2_cursor_transfers", cur_fires, 2);
        chk("t3_vec_drained", vec_q.size(), 0);

        // 4+5: no cursor points, no vectors -> one-cycle cursor window, then timeout park
        @(negedge clk);
        cur_q.delete();
        exp_q.push_back(mk(128, 128, 1, 0, 17));
        exp_q.push_back(mk(128, 128, 0, 1, 0));
        tick();
        @(negedge clk);
        chk("t4_cur_ready_in_cur", cur_ready, 1);
        @(negedge clk);
        chk("t4_cur_ready_after", cur_ready, 0);
        chk("t4_vec_ready", vec_ready, 1);
        wait_halt(1'b1, "t5_timeout_park");
        chk("t4_no_cursor_transfer", cur_fires, 2);
        chk("t5_park_xch", xch, 128);

        // 6: frame_tick during VEC -> overrun pulse, one-cycle PARK, automatic restart
        @(negedge clk);
        base = ovr_cycles;
        vec_q.push_back(pt(1, 2, 0));
        vec_q.push_back(pt(3, 4, 1));
        exp_q.push_back(mk(128, 128, 1, 0, 2));
        exp_q.push_back(mk(1, 2, 1, 0, 4));
        exp_q.push_back(mk(3, 4, 1, 0, 4));
        exp_q.push_back(mk(128, 128, 0, 1, 1));
        exp_q.push_back(mk(128, 128, 1, 0, 17));
        exp_q.push_back(mk(128, 128, 0, 1, 0));
        tick();
        tick();
        wait_halt(1'b1, "t6_first_park");
        wait_halt(1'b0, "t6_restart");
        wait_halt(1'b1, "t6_second_park");
        chk("t6_overrun_cycles", ovr_cycles - base, 1);

        // 7: reset mid-cursor drops the point and a pending tick
        @(negedge clk);
        cur_q.push_back(pt(5, 6, 0));
        exp_q.push_back(mk(128, 128, 1, 0, 1));
        exp_q.push_back(mk(5, 6, 1, 0, 2));
        exp_q.push_back(mk(128, 128, 0, 1, 0));
        tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_halt_after_rst", halt_flag, 1);
        chk("t7_go_after_rst", go_flag, 0);
        chk("t7_xch_after_rst", xch, 128);
        chk("t7_cur_ready_after_rst", cur_ready, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
